breakout_game_ctrl: RTL and testbench
=====================================

// Module: breakout_game_ctrl
// PURPOSE
//  Game-state sequencer for the breakout datapath. Sits between Keypad/pong_graph and the top-level mux.
//  Owns the newgame/play/newball/over FSM, balls-remaining count, BCD score and inter-ball delay.
//  Drives pong_graph's freeze (gra_still) and ball-respawn controls; exports state/score for text and Seg7 display.
// PARAMETERS
//  BALLS           3      balls per game, 1..7
//  NEWBALL_FRAMES  120    frame_tick count spent in NEWBALL before auto-serve, >=1
//  OVER_FRAMES     600    frame_tick count in OVER before auto-return to NEWGAME, >=1
//  KEY_START       5'h10  Keypad keyCode that starts or serves
// PORTS
//  clk            in   1   system clock; all logic on posedge
//  reset          in   1   asynchronous, active-high; clears all state
//  key_ready      in   1   Keypad ready level, synchronous to clk
//  key_code       in   5   Keypad keyCode, valid while key_ready=1
//  frame_tick     in   1   one-clk pulse per video frame
//  hit            in   1   one-clk pulse: paddle/brick hit from pong_graph
//  miss           in   1   one-clk pulse: ball lost from pong_graph
//  bricks_clear   in   1   level: no bricks remain
//  state          out  2   00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//  gra_still      out  1   1 = graph frozen (every state except PLAY)
//  ball_reset     out  1   one-clk pulse: re-centre ball
//  balls_left     out  3   remaining balls, binary
//  score          out  16  4-digit packed BCD {d3,d2,d1,d0}
//  win            out  1   1 = last game ended by clearing the bricks
// BEHAVIOUR
//  - Reset: state=NEWGAME, gra_still=1, ball_reset=0, balls_left=BALLS, score=16'h0000, win=0, timer=0.
//  - All outputs registered. A qualifying event at edge N is visible after edge N+1.
//  - start_evt = key_ready & ~key_ready_q & (key_code==KEY_START).
//    key_ready_q is a 1-flop delay, reset to 0. A held key gives exactly one start_evt.
//  - gra_still = (next state != PLAY), registered together with state.
//  - NEWGAME: on start_evt: score=0, balls_left=BALLS, win=0, ball_reset pulse, go to PLAY.
//  - PLAY: events are checked in this order:
//     bricks_clear=1: win=1, timer=OVER_FRAMES, go to OVER. A same-cycle miss is ignored; a same-cycle hit still scores.
//     miss with balls_left==1: balls_left=0, timer=OVER_FRAMES, go to OVER, win=0.
//     miss with balls_left>1: balls_left-1, timer=NEWBALL_FRAMES, go to NEWBALL.
//     hit: score BCD +1 with decimal carry, saturating at 16'h9999. Coincident with miss, both take effect.
//  - NEWBALL: timer decrements on each frame_tick.
//     When timer==1 and frame_tick=1, or on start_evt (early serve): ball_reset pulse, go to PLAY.
//  - OVER: score and win hold; timer decrements on frame_tick.
//     When timer==1 and frame_tick=1: go to NEWGAME (score held until the next start).
//     On start_evt: same action as NEWGAME start, directly to PLAY.
//  - hit/miss/bricks_clear are ignored outside PLAY. frame_tick is ignored in NEWGAME and PLAY.
//  - timer width is $clog2(max(NEWBALL_FRAMES,OVER_FRAMES)+1). The timer never wraps below 0.
//  - ball_reset is high for exactly one clk per PLAY entry and 0 otherwise.
//  - reset asserted mid-game: all outputs return to their reset values immediately (async).
//    The first edge after release behaves as a fresh NEWGAME.
// TESTING
//  1. Reset, then start key (5'h10 rising): state 00->01 after 1 clk; ball_reset 1 clk; gra_still=0; balls_left=3; score=0000.
//  2. In PLAY, 12 hit pulses: score=16'h0012. Preload 16'h9999 and hit: score stays 9999.
//  3. BALLS=3, NEWBALL_FRAMES=4: miss -> NEWBALL, balls_left=2, gra_still=1.
//     After 4 frame_ticks -> PLAY with ball_reset pulse. A start key after 1 tick serves early.
//  4. Third miss -> OVER, balls_left=0, win=0. OVER_FRAMES=3: after 3 ticks -> NEWGAME, score retained.
//     Start key -> score=0, balls_left=3.
//  5. hit+miss same clk at score 0099, balls 2: score=0100, balls_left=1, state NEWBALL.
//     bricks_clear+miss same clk: OVER, win=1, balls_left unchanged.
//  6. Hold key_ready=1 with 5'h10 for 50 clks: exactly one start_evt.
//     Wrong code 5'h0c: no transition. Assert reset mid-NEWBALL: all outputs equal reset values asynchronously.

Source files
------------

// File: rtl/breakout_game_ctrl.sv
// Game-state sequencer for the breakout datapath: newgame/play/newball/over
// FSM, balls-remaining count, packed-BCD score and inter-ball frame delay.
module breakout_game_ctrl #(
  parameter int         BALLS          = 3,
  parameter int         NEWBALL_FRAMES = 120,
  parameter int         OVER_FRAMES    = 600,
  parameter logic [4:0] KEY_START      = 5'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_ready,
  input  logic [4:0]  key_code,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        miss,
  input  logic        bricks_clear,
  output logic [1:0]  state,
  output logic        gra_still,
  output logic        ball_reset,
  output logic [2:0]  balls_left,
  output logic [15:0] score,
  output logic        win
);

  localparam int TMAX = (NEWBALL_FRAMES > OVER_FRAMES) ? NEWBALL_FRAMES : OVER_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t        st;
  logic [TW-1:0] timer;
  logic          key_ready_q;
  logic          start_evt;

  assign state = st;

  // One start event per key press: rising edge of key_ready with the start code.
  assign start_evt = key_ready & ~key_ready_q & (key_code == KEY_START);

  // Decimal +1 on the packed score, pinned at 9999 so it never rolls over.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Previous key_ready level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_ready_q <= 1'b0;
    else       key_ready_q <= key_ready;
  end

  // Game FSM; gra_still is registered alongside the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= NEWGAME;
      gra_still  <= 1'b1;
      ball_reset <= 1'b0;
      balls_left <= 3'(BALLS);
      score      <= 16'h0000;
      win        <= 1'b0;
      timer      <= '0;
    end else begin
      ball_reset <= 1'b0;
      case (st)
        NEWGAME: begin
          if (start_evt) begin
            score      <= 16'h0000;
            balls_left <= 3'(BALLS);
            win        <= 1'b0;
            ball_reset <= 1'b1;
            st         <= PLAY;
            gra_still  <= 1'b0;
          end
        end
        PLAY: begin
          // A hit scores even when the same cycle also ends the ball or game.
          if (hit) score <= bcd_inc(score);
          if (bricks_clear) begin
            win       <= 1'b1;
            timer     <= TW'(OVER_FRAMES);
            st        <= OVER;
            gra_still <= 1'b1;
          end else if (miss) begin
            if (balls_left == 3'd1) begin
              balls_left <= 3'd0;
              win        <= 1'b0;
              timer      <= TW'(OVER_FRAMES);
              st         <= OVER;
            end else begin
              balls_left <= balls_left - 3'd1;
              timer      <= TW'(NEWBALL_FRAMES);
              st         <= NEWBALL;
            end
            gra_still <= 1'b1;
          end
        end
        NEWBALL: begin
          if (frame_tick && timer != '0) timer <= timer - TW'(1);
          // Serve when the delay runs out, or early on a start key.
          if (start_evt || (frame_tick && timer == TW'(1))) begin
            ball_reset <= 1'b1;
            st         <= PLAY;
            gra_still  <= 1'b0;
          end
        end
        OVER: begin
          if (start_evt) begin
            score      <= 16'h0000;
            balls_left <= 3'(BALLS);
            win        <= 1'b0;
            ball_reset <= 1'b1;
            st         <= PLAY;
            gra_still  <= 1'b0;
          end else if (frame_tick) begin
            if (timer != '0) timer <= timer - TW'(1);
            // Score and win stay visible on the title screen until next start.
            if (timer == TW'(1)) st <= NEWGAME;
          end
        end
        default: st <= NEWGAME;
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: game-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_breakout_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ready, frame_tick, hit, miss, bricks_clear;
  logic [4:0]  key_code;
  logic [1:0]  state;
  logic        gra_still, ball_reset, win;
  logic [2:0]  balls_left;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  breakout_game_ctrl #(
    .BALLS(3), .NEWBALL_FRAMES(4), .OVER_FRAMES(3), .KEY_START(5'h10)
  ) dut (
    .clk(clk), .reset(reset), .key_ready(key_ready), .key_code(key_code),
    .frame_tick(frame_tick), .hit(hit), .miss(miss), .bricks_clear(bricks_clear),
    .state(state), .gra_still(gra_still), .ball_reset(ball_reset),
    .balls_left(balls_left), .score(score), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game in plain integers (score as a decimal number).
  int m_state, m_balls, m_score, m_timer;
  bit m_win, m_br, m_key_prev;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  always @(posedge clk or posedge reset) begin
    bit go;
    if (reset) begin
      m_state = 0; m_balls = 3; m_score = 0; m_timer = 0;
      m_win = 0; m_br = 0; m_key_prev = 0;
    end else begin
      go = key_ready && !m_key_prev && key_code == 5'h10;
      m_br = 0;
      if (m_state == 0 || (m_state == 3 && go)) begin
        if (go) begin
          m_score = 0; m_balls = 3; m_win = 0; m_br = 1; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (hit && m_score < 9999) m_score++;
        if (bricks_clear) begin
          m_win = 1; m_timer = 3; m_state = 3;
        end else if (miss) begin
          m_balls--;
          if (m_balls == 0) begin m_win = 0; m_timer = 3; m_state = 3; end
          else begin m_timer = 4; m_state = 2; end
        end
      end else if (m_state == 2) begin
        if (go || (frame_tick && m_timer == 1)) begin m_br = 1; m_state = 1; end
        if (frame_tick && m_timer > 0) m_timer--;
      end else begin
        if (frame_tick) begin
          if (m_timer == 1) m_state = 0;
          if (m_timer > 0) m_timer--;
        end
      end
      m_key_prev = key_ready;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_gra_still", 32'(gra_still), 32'(m_state != 1));
    chk("m_ball_reset", 32'(ball_reset), 32'(m_br));
    chk("m_balls_left", 32'(balls_left), 32'(m_balls));
    chk("m_score", 32'(score), 32'(to_bcd(m_score)));
    chk("m_win", 32'(win), 32'(m_win));
  end

  task automatic press(input logic [4:0] c);
    key_code = c; key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    repeat (n) @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; key_ready = 0; key_code = 0; frame_tick = 0;
    hit = 0; miss = 0; bricks_clear = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_gra_still", 32'(gra_still), 32'h1);
    chk("rst_balls", 32'(balls_left), 32'h3);
    chk("rst_score", 32'(score), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Start from NEWGAME
    press(5'h10);
    chk("start_state", 32'(state), 32'h1);
    chk("start_ball_reset", 32'(ball_reset), 32'h1);
    chk("start_gra_still", 32'(gra_still), 32'h0);
    @(negedge clk);
    chk("ball_reset_1clk", 32'(ball_reset), 32'h0);

    hits(12);
    chk("score_12", 32'(score), 32'h0012);

    // Miss -> NEWBALL, 4 frame ticks -> serve
    pulse_miss();
    chk("nb_state", 32'(state), 32'h2);
    chk("nb_balls", 32'(balls_left), 32'h2);
    chk("nb_gra_still", 32'(gra_still), 32'h1);
    repeat (3) tick();
    chk("nb_wait", 32'(state), 32'h2);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("nb_serve_state", 32'(state), 32'h1);
    chk("nb_serve_br", 32'(ball_reset), 32'h1);

    // Coincident hit+miss at 0099 with two balls
    hits(87);
    chk("score_99", 32'(score), 32'h0099);
    hit = 1'b1; miss = 1'b1;
    @(negedge clk);
    hit = 1'b0; miss = 1'b0;
    chk("hm_score", 32'(score), 32'h0100);
    chk("hm_balls", 32'(balls_left), 32'h1);
    chk("hm_state", 32'(state), 32'h2);

    // Early serve after one tick
    tick();
    press(5'h10);
    chk("early_state", 32'(state), 32'h1);
    chk("early_br", 32'(ball_reset), 32'h1);

    // Last ball lost -> OVER -> NEWGAME after 3 ticks
    pulse_miss();
    chk("over_state", 32'(state), 32'h3);
    chk("over_balls", 32'(balls_left), 32'h0);
    chk("over_win", 32'(win), 32'h0);
    repeat (3) tick();
    chk("over_to_newgame", 32'(state), 32'h0);
    chk("over_score_kept", 32'(score), 32'h0100);
    press(5'h10);
    chk("restart_score", 32'(score), 32'h0);
    chk("restart_balls", 32'(balls_left), 32'h3);

    // bricks_clear beats a same-cycle miss
    bricks_clear = 1'b1; miss = 1'b1;
    @(negedge clk);
    bricks_clear = 1'b0; miss = 1'b0;
    chk("clear_state", 32'(state), 32'h3);
    chk("clear_win", 32'(win), 32'h1);
    chk("clear_balls", 32'(balls_left), 32'h3);
    press(5'h10);
    chk("over_start_state", 32'(state), 32'h1);
    chk("over_start_win", 32'(win), 32'h0);

    // Saturation at 9999
    hits(9999);
    chk("score_9999", 32'(score), 32'h9999);
    hits(1);
    chk("score_sat", 32'(score), 32'h9999);
    bricks_clear = 1'b1;
    @(negedge clk);
    bricks_clear = 1'b0;
    repeat (3) tick();
    chk("sat_newgame", 32'(state), 32'h0);

    // Wrong code, then held start key
    press(5'h0c);
    @(negedge clk);
    chk("wrong_code", 32'(state), 32'h0);
    key_code = 5'h10; key_ready = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (ball_reset) cnt++;
    end
    key_ready = 1'b0;
    chk("hold_one_start", 32'(cnt), 32'd1);
    chk("hold_state", 32'(state), 32'h1);

    // Async reset in NEWBALL
    pulse_miss();
    chk("pre_rst_state", 32'(state), 32'h2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_gra_still", 32'(gra_still), 32'h1);
    chk("arst_br", 32'(ball_reset), 32'h0);
    chk("arst_balls", 32'(balls_left), 32'h3);
    chk("arst_score", 32'(score), 32'h0);
    chk("arst_win", 32'(win), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(state), 32'h0);
    press(5'h10);
    chk("post_rst_start", 32'(state), 32'h1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
